// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and one-cycle result strobes.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report parity errors.
module uart_rx #(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy,
    output logic       parity_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    // Even parity: nonzero result means the received parity bit disagrees with the data.
    function automatic logic even_parity_err(input logic [7:0] d, input logic p);
        return (^d) ^ p;
    endfunction
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

    state_t          state_r;
    state_t          state_nxt_s;
    logic            rx_meta_r;
    logic            rx_sync_r;
    logic            rx_s;
    logic [CW-1:0]   cnt_r;
    logic [2:0]      bit_r;
    logic [7:0]      shift_r;
    logic            cnt_clr_s;
    logic            shift_en_s;
    logic            good_s;
    logic            ferr_s;
`ifdef UART_RX_PARITY_EN
    logic            par_r;
    logic            par_en_s;
    logic            perr_s;
    logic            perr_r;
`endif

    assign rx_s = rx_sync_r;

    // Two-flop synchronizer for the asynchronous line; idles high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        state_nxt_s = state_r;
        cnt_clr_s   = 1'b0;
        shift_en_s  = 1'b0;
        good_s      = 1'b0;
        ferr_s      = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_en_s    = 1'b0;
        perr_s      = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                cnt_clr_s = 1'b1;
                if (!rx_s) begin
                    state_nxt_s = START;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_clr_s = 1'b1;
                    if (!rx_s) begin
                        state_nxt_s = DATA;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = START;
                end
            end
            DATA: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_clr_s  = 1'b1;
                    shift_en_s = 1'b1;
                    if (bit_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt_s = PARITY;
`else
                        state_nxt_s = STOP;
`endif
                    end else begin
                        state_nxt_s = DATA;
                    end
                end else begin
                    state_nxt_s = DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_clr_s   = 1'b1;
                    par_en_s    = 1'b1;
                    state_nxt_s = STOP;
                end else begin
                    state_nxt_s = PARITY;
                end
            end
`endif
            STOP: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_clr_s = 1'b1;
                    if (rx_s) begin
                        // Leaving at mid-stop lets a start bit right after a single stop bit be caught.
                        state_nxt_s = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (even_parity_err(shift_r, par_r)) begin
                            perr_s = 1'b1;
                        end else begin
                            good_s = 1'b1;
                        end
`else
                        good_s = 1'b1;
`endif
                    end else begin
                        ferr_s      = 1'b1;
                        state_nxt_s = BREAK;
                    end
                end else begin
                    state_nxt_s = STOP;
                end
            end
            BREAK: begin
                cnt_clr_s = 1'b1;
                if (rx_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = BREAK;
                end
            end
            default: begin
                cnt_clr_s   = 1'b1;
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            bit_r     <= 3'd0;
            shift_r   <= 8'h00;
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_clr_s ? '0 : cnt_r + CW'(1);
            if (shift_en_s) begin
                shift_r <= {rx_s, shift_r[7:1]};
                bit_r   <= bit_r + 3'd1;
            end else if (state_r == IDLE) begin
                bit_r   <= 3'd0;
            end
            if (good_s) begin
                data <= shift_r;
            end
            valid     <= good_s;
            frame_err <= ferr_s;
            busy      <= (state_nxt_s != IDLE);
        end
    end

`ifdef UART_RX_PARITY_EN
    // Captured parity bit and its error strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_r  <= 1'b0;
            perr_r <= 1'b0;
        end else begin
            if (par_en_s) begin
                par_r <= rx_s;
            end
            perr_r <= perr_s;
        end
    end

    assign parity_err = perr_r;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx: drives serial frames and
// compares observed strobes against an expected-event queue built from frame contents.
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int H   = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;
    logic       parity_err;

    int n_vec;
    int n_err;
    int excl_cnt;
    logic [7:0] last_good;
    logic [9:0] exp_q[$];
    logic [9:0] obs_q[$];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .frame_err  (frame_err),
        .busy       (busy),
        .parity_err (parity_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Event log: kind 0 = valid with byte, 1 = frame error, 2 = parity error.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid)      obs_q.push_back({2'd0, data});
            if (frame_err)  obs_q.push_back({2'd1, 8'h00});
            if (parity_err) obs_q.push_back({2'd2, 8'h00});
            if (int'(valid) + int'(frame_err) + int'(parity_err) > 1) excl_cnt++;
        end
    end

    task automatic hold_rx(input logic v, input int cycles);
        rx = v;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
        if (!stop_bit) begin
            exp_q.push_back({2'd1, 8'h00});
        end else if (PAR_EN && ((^b) ^ par_bit)) begin
            exp_q.push_back({2'd2, 8'h00});
        end else begin
            exp_q.push_back({2'd0, b});
            last_good = b;
        end
        hold_rx(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold_rx(b[i], CPB);
        if (PAR_EN) hold_rx(par_bit, CPB);
        hold_rx(stop_bit, CPB);
    endtask

    task automatic compare_events(input string tag);
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk({tag, "_event"}, obs_q[i], exp_q[i]);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        int lat;
        int gap;
        logic [7:0] b;
        logic sb;
        logic pb;
        n_vec = 0;
        n_err = 0;
        excl_cnt = 0;
        last_good = 8'h00;
        rx = 1'b1;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_data", data, 8'h00);
        chk("rst_valid", valid, 1'b0);
        chk("rst_ferr", frame_err, 1'b0);
        chk("rst_perr", parity_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        hold_rx(1'b1, 2 * CPB);

        // 'U' with latency measured from the start-bit falling edge.
        lat = 0;
        fork
            send_frame(8'h55, 1'b1, ^8'h55);
            begin
                while (lat < 400) begin
                    @(posedge clk);
                    lat++;
                    #1;
                    if (valid) break;
                end
            end
        join
        chk("latency", lat, 3 + H + 9 * CPB + (PAR_EN ? CPB : 0));
        hold_rx(1'b1, CPB);
        compare_events("u55");
        chk("u55_data", data, 8'h55);

        // Back-to-back frames with a single stop bit.
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        hold_rx(1'b1, CPB);
        compare_events("b2b");
        chk("b2b_data", data, 8'hFF);

        // Short low glitch from idle: false start.
        hold_rx(1'b0, 5);
        chk("glitch_busy_hi", busy, 1'b1);
        hold_rx(1'b0, 1);
        hold_rx(1'b1, 6);
        chk("glitch_busy_lo", busy, 1'b0);
        hold_rx(1'b1, 2 * CPB);
        compare_events("glitch");

        // Bad stop bit then line held low, recovery, next byte.
        send_frame(8'hA5, 1'b0, ^8'hA5);
        hold_rx(1'b0, 5 * CPB);
        chk("break_data", data, last_good);
        chk("break_busy", busy, 1'b1);
        hold_rx(1'b1, 2 * CPB);
        send_frame(8'h3C, 1'b1, ^8'h3C);
        hold_rx(1'b1, CPB);
        compare_events("break");
        chk("break_next_data", data, 8'h3C);

        // Reset during bit 4 of 8'h81 discards the frame.
        hold_rx(1'b0, CPB);
        b = 8'h81;
        for (int i = 0; i < 4; i++) hold_rx(b[i], CPB);
        hold_rx(b[4], H / 2);
        rst = 1'b1;
        rx = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_data", data, 8'h00);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_strobe", {valid, frame_err, parity_err}, 3'b000);
        @(negedge clk);
        repeat (9) @(negedge clk);
        rst = 1'b0;
        last_good = 8'h00;
        hold_rx(1'b1, 2 * CPB);
        send_frame(8'h42, 1'b1, ^8'h42);
        hold_rx(1'b1, CPB);
        compare_events("midrst");
        chk("midrst_next_data", data, 8'h42);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        hold_rx(1'b1, CPB);
        chk("perr_data", data, 8'h42);
        send_frame(8'h07, 1'b1, 1'b1);
        hold_rx(1'b1, CPB);
        compare_events("parity");
        chk("parity_data", data, 8'h07);
`endif

        // Random frames: occasional bad stop or parity, random idle gaps.
        for (int f = 0; f < 24; f++) begin
            b  = 8'($urandom);
            sb = ($urandom_range(0, 9) != 0);
            pb = ($urandom_range(0, 3) == 0) ? ~(^b) : (^b);
            send_frame(b, sb, pb);
            gap = $urandom_range(0, 2) * CPB + $urandom_range(0, 3);
            if (!sb && gap < CPB) gap = CPB;
            if (gap > 0) hold_rx(1'b1, gap);
        end
        hold_rx(1'b1, 2 * CPB);
        compare_events("rand");
        chk("rand_data", data, last_good);
        chk("rand_idle_busy", busy, 1'b0);
        chk("strobe_exclusive", excl_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
